// File: rtl/sound_player_if.sv
// Request/response bundle between a sound-request block and the sound player.
// go is a level request; the player answers with busy while the tone runs and a one-cycle done when it ends.
interface sound_player_if;
    // go: the requester raises go to start a note and holds it for the whole note;
    // a new note starts only on a rising edge of go seen while the player is idle.
    // busy is high while the note sounds; done pulses for exactly one cycle when it ends.
    // There is no backpressure: a rising edge that arrives while the player is not idle is dropped.
    logic       go;
    logic [5:0] sound;
    logic       audio;
    logic       busy;
    logic       done;

    modport master (
        output go,
        output sound,
        input  audio,
        input  busy,
        input  done
    );

    modport slave (
        input  go,
        input  sound,
        output audio,
        output busy,
        output done
    );
endinterface

// File: rtl/sound_player.sv
// Square-wave note renderer: latches a sound code on a rising edge of go and toggles audio
// every half-period until go falls or the watchdog expires.
module sound_player #(
    parameter int MAX_TICKS = 60_000_000
) (
    input  logic                 clock,
    input  logic                 resetn,
    sound_player_if.slave        snd,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(MAX_TICKS - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_go_q;
    logic [5:0]  r_code;
    logic [16:0] r_phase;
    logic [25:0] r_tick;
    logic        r_audio;

    logic        w_go_rise;
    logic        w_watchdog;
    logic        w_phase_wrap;
    logic        w_silent;
    logic [16:0] w_base;
    logic [16:0] w_half;

    // Octave-0 half-periods in 50 MHz cycles; index 0 is silence and has no period.
    always_comb begin
        w_base = 17'd0;
        case (r_code[2:0])
            3'd1:    w_base = 17'd95556;
            3'd2:    w_base = 17'd85131;
            3'd3:    w_base = 17'd75843;
            3'd4:    w_base = 17'd71586;
            3'd5:    w_base = 17'd63776;
            3'd6:    w_base = 17'd56818;
            3'd7:    w_base = 17'd50619;
            default: w_base = 17'd0;
        endcase
    end

    assign w_half       = w_base >> r_code[5:3];
    assign w_silent     = (r_code[2:0] == 3'd0);
    assign w_phase_wrap = (r_phase == (w_half - 17'd1));
    assign w_go_rise    = snd.go & ~r_go_q;
    assign w_watchdog   = (r_tick == TICK_LAST);

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // go falling wins over the watchdog when both happen on the same edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go_rise) w_next = ST_PLAY;
            ST_PLAY: begin
                if (!snd.go)         w_next = ST_DONE;
                else if (w_watchdog) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_go_q  <= 1'b0;
            r_code  <= 6'd0;
            r_phase <= 17'd0;
            r_tick  <= 26'd0;
            r_audio <= 1'b0;
        end else begin
            r_go_q <= snd.go;
            case (r_state)
                ST_IDLE: begin
                    r_audio <= 1'b0;
                    if (w_go_rise) begin
                        r_code  <= snd.sound;
                        r_phase <= 17'd0;
                        r_tick  <= 26'd0;
                    end
                end
                ST_PLAY: begin
                    if (w_next != ST_PLAY) begin
                        r_audio <= 1'b0;
                    end else begin
                        r_tick <= r_tick + 26'd1;
                        if (w_phase_wrap) begin
                            r_phase <= 17'd0;
                            if (!w_silent) r_audio <= ~r_audio;
                        end else begin
                            r_phase <= r_phase + 17'd1;
                        end
                    end
                end
                default: r_audio <= 1'b0;
            endcase
        end
    end

    assign snd.audio   = r_audio;
    assign snd.busy    = (r_state == ST_PLAY);
    assign snd.done    = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player: each started note pushes its expected length and half-period,
// and a negedge monitor measures the note and compares when done pulses.
module tb_sound_player;

    typedef struct packed {
        logic [31:0] len;
        logic [31:0] half;
    } exp_t;

    logic clock;
    logic rst;
    logic sel;
    logic [1:0] dbg_a;
    logic [1:0] dbg_w;

    int checks;
    int failures;
    exp_t exp_q[$];

    sound_player_if if_a ();
    sound_player_if if_w ();

    sound_player dut_a (
        .clock       (clock),
        .resetn      (rst),
        .snd         (if_a),
        .o_dbg_state (dbg_a)
    );

    sound_player #(.MAX_TICKS(1000)) dut_w (
        .clock       (clock),
        .resetn      (rst),
        .snd         (if_w),
        .o_dbg_state (dbg_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // monitor on the selected DUT
    logic m_busy, m_audio, m_done;
    assign m_busy  = sel ? if_w.busy  : if_a.busy;
    assign m_audio = sel ? if_w.audio : if_a.audio;
    assign m_done  = sel ? if_w.done  : if_a.done;

    logic prev_busy, prev_audio, prev_done, active;
    exp_t cur;
    int len, last_tog, toggles, bad_iv, stray, exp_tog;

    initial begin
        prev_busy = 0; prev_audio = 0; prev_done = 0; active = 0;
        len = 0; last_tog = 0; toggles = 0; bad_iv = 0; stray = 0;
        cur = '0;
    end

    always @(negedge clock) begin
        if (rst) begin
            active     = 0;
            prev_busy  = 0;
            prev_audio = 0;
            prev_done  = 0;
        end else begin
            if (m_busy && !prev_busy) begin
                chk("start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur    = exp_q.pop_front();
                    active = 1;
                end
                len = 1; last_tog = 1; toggles = 0; bad_iv = 0;
                if (m_audio !== 1'b0) bad_iv++;
            end else if (m_busy) begin
                len++;
                if (m_audio !== prev_audio) begin
                    toggles++;
                    if (len - last_tog != int'(cur.half)) bad_iv++;
                    last_tog = len;
                end
            end
            if (!m_busy && m_audio !== 1'b0) stray++;
            if (m_done) begin
                chk("done_single_cycle", int'(prev_done), 0);
                if (!prev_done) begin
                    chk("done_after_note", int'(active), 1);
                    if (active) begin
                        exp_tog = (cur.half == 0) ? 0 : (int'(cur.len) - 1) / int'(cur.half);
                        chk("busy_len", len, int'(cur.len));
                        chk("toggle_count", toggles, exp_tog);
                        chk("toggle_interval_errs", bad_iv, 0);
                        active = 0;
                    end
                end
            end
            prev_busy  = m_busy;
            prev_audio = m_audio;
            prev_done  = m_done;
        end
    end

    task automatic play_a(input logic [5:0] code, input int cycles, input int half);
        @(posedge clock);
        #1;
        if_a.sound = code;
        exp_q.push_back('{len: cycles, half: half});
        if_a.go = 1'b1;
        repeat (cycles) @(posedge clock);
        #1 if_a.go = 1'b0;
    endtask

    task automatic play_w(input logic [5:0] code, input int cycles, input int half);
        @(posedge clock);
        #1;
        if_w.sound = code;
        exp_q.push_back('{len: cycles, half: half});
        if_w.go = 1'b1;
        repeat (cycles) @(posedge clock);
        #1 if_w.go = 1'b0;
    endtask

    task automatic chk_quiet_a(input string tag);
        chk({tag, "_busy"}, int'(if_a.busy), 0);
        chk({tag, "_done"}, int'(if_a.done), 0);
        chk({tag, "_audio"}, int'(if_a.audio), 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; sel = 1'b0;
        if_a.go = 1'b0; if_a.sound = 6'd0;
        if_w.go = 1'b0; if_w.sound = 6'd0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk_quiet_a("reset");
        chk("reset_state", int'(dbg_a), 0);
        chk("reset_busy_w", int'(if_w.busy), 0);
        rst = 1'b0;

        // tone at the highest pitch: half-period 395
        play_a(6'b111_111, 5000, 395);
        repeat (5) @(posedge clock);
        #1 chk_quiet_a("after_tone");

        // silence
        play_a(6'b000_000, 1000, 0);
        repeat (5) @(posedge clock);

        // latched code: 56818 >> 7 = 443, sound changes mid-note
        @(posedge clock);
        #1;
        if_a.sound = 6'b111_110;
        exp_q.push_back('{len: 1000, half: 443});
        if_a.go = 1'b1;
        repeat (500) @(posedge clock);
        #1 if_a.sound = 6'b111_111;
        repeat (500) @(posedge clock);
        #1 if_a.go = 1'b0;
        repeat (5) @(posedge clock);

        // rising edge during DONE is lost
        play_a(6'b111_111, 300, 395);
        @(posedge clock);
        #1 if_a.go = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        chk("lost_edge_busy", int'(if_a.busy), 0);
        chk("lost_edge_state", int'(dbg_a), 0);
        if_a.go = 1'b0;
        repeat (2) @(posedge clock);
        play_a(6'b111_111, 200, 395);
        repeat (5) @(posedge clock);

        // back-to-back: long low note with no toggle, then a high note
        play_a(6'b000_001, 2000, 95556);
        repeat (3) @(posedge clock);
        play_a(6'b111_111, 800, 395);
        repeat (5) @(posedge clock);

        // watchdog on the short-limit instance
        #1 sel = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        if_w.sound = 6'b111_111;
        exp_q.push_back('{len: 1000, half: 395});
        if_w.go = 1'b1;
        repeat (3000) @(posedge clock);
        #1;
        chk("watchdog_no_restart_busy", int'(if_w.busy), 0);
        chk("watchdog_sb_drained", exp_q.size(), 0);
        if_w.go = 1'b0;
        repeat (2) @(posedge clock);
        play_w(6'b111_111, 500, 395);
        repeat (5) @(posedge clock);

        // asynchronous reset in the middle of a note, while audio is high
        #1 sel = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if_a.sound = 6'b111_111;
        exp_q.push_back('{len: 0, half: 395});
        if_a.go = 1'b1;
        repeat (500) @(posedge clock);
        #1;
        chk("pre_reset_audio", int'(if_a.audio), 1);
        chk("pre_reset_busy", int'(if_a.busy), 1);
        rst = 1'b1;
        #1 chk_quiet_a("reset_mid_note");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_quiet_a("reset_held");
        end
        if_a.go = 1'b0;
        @(posedge clock);
        #1 rst = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk_quiet_a("after_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("no_note_in_flight", int'(active), 0);
        chk("audio_outside_play", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_player.md
# sound_player

Consumer end of the game-sound interface: accepts the level-held `go` strobe and 6-bit sound code produced by the sound-request blocks, and renders the requested note as a 1-bit square wave for the audio output stage. A rising edge on `go` latches the code and starts the tone. The tone ends when `go` falls or when a watchdog limit expires. The block reports `busy` while sounding and pulses `done` once at the end of each note.

## Interface
- `MAX_TICKS`, default 60_000_000: watchdog length of one note, in clock cycles (26-bit compare).
- `clock` input 1: system clock, 50 MHz; all state updates on the rising edge.
- `resetn` input 1: reset, asynchronous and active-high (despite the name). `resetn = 1` clears all state.
- `go` input 1: level request from the sound-request block, held high for the note duration.
- `sound` input 6: sound code. `[5:3]` = octave shift 0–7; `[2:0]` = note index, where 0 means silence.
- `audio` output 1: square-wave tone.
- `busy` output 1: high while a note is in progress (state PLAY).
- `done` output 1: one-cycle pulse when a note ends.

## Operation
- **State machine:** IDLE, PLAY, DONE. Two-bit state register.
- **Edge detect:** `go_q` is `go` registered each cycle. `go_rise = go & ~go_q`.
- **IDLE:**
  - On `go_rise`, latch `sound` into `code_r`, clear the phase counter and tick counter, and go to PLAY.
  - When `go` is high but there is no rise (for example, `go` still held after a note), stay in IDLE.
- **PLAY:**
  - If `go == 0`, go to DONE.
  - Otherwise, if `tick == MAX_TICKS - 1`, go to DONE (watchdog).
  - Otherwise, increment `tick`.
  - `go` low takes priority over the watchdog when both occur in the same cycle.
- **DONE:** lasts exactly one cycle, then goes to IDLE.
  - A `go_rise` during the DONE cycle is lost. It is not queued.
- **Latched code:** changes on `sound` during PLAY are ignored; `code_r` holds the latched value.
- **Half-period table** (17-bit, for octave 0):

  | Note index | Note | Half-period (cycles) |
  |---|---|---|
  | 1 | C | 95556 |
  | 2 | D | 85131 |
  | 3 | E | 75843 |
  | 4 | F | 71586 |
  | 5 | G | 63776 |
  | 6 | A | 56818 |
  | 7 | B | 50619 |

- **Effective half-period:** `half = table[code_r[2:0]] >> code_r[5:3]`, truncating. Minimum value is 50619 >> 7 = 395.
- **Tone generation in PLAY:**
  - The phase counter counts 0 to `half - 1`.
  - At `half - 1` it wraps to 0 and `audio` toggles.
  - If `code_r[2:0] == 0`, `audio` stays 0 but timing, `busy` and `done` behave normally.
- **`audio` outside PLAY:** forced to 0 on entering DONE and held at 0 in IDLE.
- **Outputs:** `busy = (state == PLAY)` and `done = (state == DONE)`, both registered state decodes.

## Timing
- **Reset values:** `audio` = 0, `busy` = 0, `done` = 0, state = IDLE, `go_q` = 0, all counters = 0.
  - Consequence: if `go` is already high when reset is released, the first edge starts a note.
- **Start latency:** `go` is sampled high at clock edge N (with `go_q` = 0). `busy` goes high after edge N.
- **First toggle:** `audio` first rises after edge N + `half`. Period = 2 × `half` cycles.
- **Stop latency:** `go` is sampled low at edge M. `busy` falls and `done` rises after edge M; `done` falls after M + 1.
- **Watchdog:** a continuously held `go` yields `busy` high for exactly `MAX_TICKS` cycles, followed by a single `done` cycle. After that, `go` must fall and rise again to start a new note.
- **Reset mid-note:** returns to IDLE immediately (asynchronous). `audio` and `busy` drop to 0 with no `done` pulse.

## Test plan
- **Reset:** assert `resetn` = 1 during PLAY. `audio`, `busy` and `done` must be 0 within the same cycle and remain 0 while reset is held.
- **Tone:** `sound` = 6'b111_111, `go` high for 5000 cycles. `busy` is high for 5000 cycles, `audio` toggles every 395 cycles with the first rise 395 cycles after `busy` rises, then one `done` pulse, then `audio` = 0.
- **Silence plus latch:**
  - `sound` = 6'b000_000, `go` high for 1000 cycles. `audio` stays 0, `busy` is high for 1000 cycles, and `done` pulses once.
  - Repeat with `sound` = 6'b111_110 (half-period 443), then change `sound` to 6'b111_111 mid-note. The half-period must remain 443.
- **Watchdog:** `MAX_TICKS` = 1000, `go` held high for 3000 cycles.
  - `busy` is high for exactly 1000 cycles, then `done` pulses once.
  - No restart while `go` stays high.
  - Dropping and re-raising `go` starts a new note.
- **Edge lost in DONE:** `go` falls at edge M and rises again at edge M + 1. No new note starts (`busy` stays 0) until `go` falls and rises again.
- **Back-to-back win/lose:**
  - `sound` = 6'b000_001 with `go` high for 2000 cycles: no toggle occurs (half-period 95556), `done` pulses once.
  - Then, 2 cycles after IDLE, `sound` = 6'b111_111 with `go` high: a new note starts with half-period 395.
